// File: rtl/segment_reader.sv
// -----------------------------------------------------------------------------
// segment_reader
//   Snoops a multiplexed 4-digit 7-segment display and rebuilds the shown
//   number. Each {sel,seg} pair must be stable for STABLE_CYCLES consecutive
//   samples before it is accepted. An accepted legal digit on a one-hot slot
//   is written into that slot's buffer. Once all four slots have been seen,
//   the buffer is presented as a frame with a valid/ready handshake. Illegal
//   select or segment patterns raise sticky error flags.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous active-high reset
//   sel          in   4   one-hot digit position (4'b0000 = blanking)
//   seg          in   7   segment lines, seg[0]=A .. seg[6]=G
//   frame_ready  in   1   consumer accepts the frame while frame_valid is high
//   clear_err    in   1   pulse that clears both sticky error flags
//   frame        out  16  frame[4i+3:4i] = slot i, bit-reversed digit code
//   frame_valid  out  1   frame holds a complete frame
//   seg_err      out  1   sticky: illegal segment pattern accepted
//   sel_err      out  1   sticky: non-zero, non-one-hot select accepted
// -----------------------------------------------------------------------------
module segment_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sel,
  input  logic [6:0]  seg,
  input  logic        frame_ready,
  input  logic        clear_err,
  output logic [15:0] frame,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        sel_err
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;
  localparam logic [3:0] RUN_MAX    = STABLE_CYCLES[3:0];

  // True when exactly one select line is high.
  function automatic logic sel_is_onehot(input logic [3:0] s);
    return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
  endfunction

  // Slot index of a one-hot select; only meaningful when sel_is_onehot().
  function automatic logic [1:0] sel_to_index(input logic [3:0] s);
    logic [1:0] idx;
    case (s)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Segment pattern -> {legal, nibble}. The nibble carries the digit with its
  // bit order reversed (bit 0 has weight 8), matching the frame encoding.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [3:0] d;
    logic       ok;
    ok = 1'b1;
    case (p)
      7'b0111111: d = 4'd0;
      7'b0000110: d = 4'd1;
      7'b1011011: d = 4'd2;
      7'b1001111: d = 4'd3;
      7'b1100110: d = 4'd4;
      7'b1101101: d = 4'd5;
      7'b1111101: d = 4'd6;
      7'b0000111: d = 4'd7;
      7'b1111111: d = 4'd8;
      7'b1101111: d = 4'd9;
      default: begin
        d  = 4'd0;
        ok = 1'b0;
      end
    endcase
    return {ok, d[0], d[1], d[2], d[3]};
  endfunction

  logic [10:0]     sample_q, sample_d;
  logic [3:0]      run_q, run_d;
  logic [3:0][3:0] slots_q, slots_d;
  logic [3:0]      seen_q, seen_d;
  logic [0:0]      state_q, state_d;
  logic [15:0]     frame_q, frame_d;
  logic            frame_valid_q, frame_valid_d;
  logic            seg_err_q, seg_err_d;
  logic            sel_err_q, sel_err_d;

  logic            accept_s;
  logic            onehot_s;
  logic [1:0]      idx_s;
  logic [4:0]      dec_s;
  logic            slot_wr_s;
  logic            sel_bad_s;
  logic            seg_bad_s;

  // Stability filter: run length of identical samples, accept once per run.
  always_comb begin
    sample_d = {sel, seg};
    if (sample_d == sample_q) begin
      if (run_q == RUN_MAX) begin
        run_d = run_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end else begin
      run_d = 4'd1;
    end
    // Fires only on the transition into saturation, so a long hold
    // produces a single accept.
    accept_s = (run_d == RUN_MAX) && (run_q != RUN_MAX);
  end

  // Classify the accepted sample.
  always_comb begin
    onehot_s  = sel_is_onehot(sel);
    idx_s     = sel_to_index(sel);
    dec_s     = decode_seg(seg);
    slot_wr_s = accept_s && onehot_s && dec_s[4];
    sel_bad_s = accept_s && (sel != 4'd0) && !onehot_s;
    seg_bad_s = accept_s && onehot_s && !dec_s[4];
  end

  // Slot buffer, seen mask and frame handshake state machine.
  always_comb begin
    slots_d       = slots_q;
    seen_d        = seen_q;
    state_d       = state_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;

    case (state_q)
      ST_COLLECT: begin
        if (seen_q == 4'hF) begin
          // Frame takes the slot values from before any same-cycle write.
          frame_d       = slots_q;
          frame_valid_d = 1'b1;
          seen_d        = 4'h0;
          state_d       = ST_HOLD;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          state_d       = ST_COLLECT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        frame_valid_d = 1'b0;
        state_d       = ST_COLLECT;
      end
    endcase

    // Applied after the frame-launch clear so a same-cycle digit is kept.
    if (slot_wr_s) begin
      slots_d[idx_s] = dec_s[3:0];
      seen_d[idx_s]  = 1'b1;
    end else begin
      slots_d = slots_d;
    end
  end

  // Sticky error flags; clear_err wins over a same-cycle set.
  always_comb begin
    if (clear_err) begin
      sel_err_d = 1'b0;
      seg_err_d = 1'b0;
    end else begin
      sel_err_d = sel_err_q | sel_bad_s;
      seg_err_d = seg_err_q | seg_bad_s;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q      <= 11'd0;
      run_q         <= 4'd0;
      slots_q       <= '0;
      seen_q        <= 4'd0;
      state_q       <= ST_COLLECT;
      frame_q       <= 16'h0000;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      sample_q      <= sample_d;
      run_q         <= run_d;
      slots_q       <= slots_d;
      seen_q        <= seen_d;
      state_q       <= state_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign sel_err     = sel_err_q;

endmodule
